// File: rtl/atid_pool_allocator_if.sv
// Request/grant and release bus of the ATID pool allocator.
// The master drives requests and releases; the allocator is the slave.
interface atid_pool_allocator_if #(
  parameter int ID_W   = 8,
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] req_valid;
  logic [NUM_CH-1:0] req_ready;
  logic [ID_W-1:0]   alloc_id;
  logic              rel_valid;
  logic [ID_W-1:0]   rel_id;
  logic              rel_err;
  logic              pool_empty;
  logic [ID_W:0]     free_count;

  modport master (
    output req_valid, rel_valid, rel_id,
    input  req_ready, alloc_id, rel_err, pool_empty, free_count
  );

  modport slave (
    input  req_valid, rel_valid, rel_id,
    output req_ready, alloc_id, rel_err, pool_empty, free_count
  );
endinterface

// File: rtl/atid_pool_allocator.sv
// ATB trace-ID pool: in-use bitmap, scanning pointer, round-robin grant to
// NUM_CH requesters, and checked release of IDs back to the pool.
module atid_pool_allocator #(
  parameter int ID_W   = 8,
  parameter int NUM_CH = 4,
  parameter int RSV_LO = 'h70,
  parameter int RSV_HI = 'h7F
) (
  input  logic                  clk,
  input  logic                  reset,
  atid_pool_allocator_if.slave  bus
);
  localparam int NID    = 2 ** ID_W;
  localparam int NVALID = NID - 1 - (RSV_HI - RSV_LO + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_SCAN, ST_READY, ST_FULL} state_t;

  state_t            state_q, state_d;
  logic [NID-1:0]    used_q, used_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   cand_id_q, cand_id_d;
  logic [CH_W-1:0]   last_gnt_q, last_gnt_d;
  logic [ID_W:0]     free_count_q, free_count_d;
  logic              rel_err_q, rel_err_d;

  logic [NID-1:0]    alloc_mask;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              rel_legal;

  // Constant mask of IDs that may ever be handed out.
  for (genvar gi = 0; gi < NID; gi++) begin : g_mask
    assign alloc_mask[gi] = (gi != 0) && !((gi >= RSV_LO) && (gi <= RSV_HI));
  end

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
    if (x == ID_W'(RSV_LO - 1))
      return ID_W'(RSV_HI + 1);
    else if (x == {ID_W{1'b1}})
      return ID_W'(1);
    else
      return x + ID_W'(1);
  endfunction

  assign rel_legal = bus.rel_valid && alloc_mask[bus.rel_id] && used_q[bus.rel_id];

  // Round-robin search starts just past the last granted channel.
  always_comb begin
    logic [CH_W-1:0] idx;
    gnt     = '0;
    gnt_idx = last_gnt_q;
    gnt_any = 1'b0;
    idx     = '0;
    if (state_q == ST_READY) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        idx = CH_W'((int'(last_gnt_q) + i) % NUM_CH);
        if (!gnt_any && bus.req_valid[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    used_d       = used_q;
    ptr_d        = ptr_q;
    cand_id_d    = cand_id_q;
    last_gnt_d   = last_gnt_q;
    free_count_d = free_count_q;
    rel_err_d    = bus.rel_valid && !rel_legal;

    case (state_q)
      ST_SCAN: begin
        if ((free_count_q == '0) && !rel_legal) begin
          state_d = ST_FULL;
        end else if (!used_q[ptr_q]) begin
          cand_id_d = ptr_q;
          state_d   = ST_READY;
        end else begin
          ptr_d = next_id(ptr_q);
        end
      end
      ST_READY: begin
        if (gnt_any) begin
          used_d[cand_id_q] = 1'b1;
          last_gnt_d        = gnt_idx;
          ptr_d             = next_id(cand_id_q);
          state_d           = ST_SCAN;
        end
      end
      ST_FULL: begin
        if (rel_legal) begin
          ptr_d   = bus.rel_id;
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    // cand_id is never in use, so a grant and a release never hit the same bit.
    if (rel_legal)
      used_d[bus.rel_id] = 1'b0;

    if (rel_legal && !gnt_any)
      free_count_d = free_count_q + (ID_W+1)'(1);
    else if (!rel_legal && gnt_any)
      free_count_d = free_count_q - (ID_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SCAN;
      used_q       <= '0;
      ptr_q        <= ID_W'(1);
      cand_id_q    <= '0;
      last_gnt_q   <= CH_W'(NUM_CH - 1);
      free_count_q <= (ID_W+1)'(NVALID);
      rel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      used_q       <= used_d;
      ptr_q        <= ptr_d;
      cand_id_q    <= cand_id_d;
      last_gnt_q   <= last_gnt_d;
      free_count_q <= free_count_d;
      rel_err_q    <= rel_err_d;
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.alloc_id   = (state_q == ST_READY) ? cand_id_q : '0;
  assign bus.pool_empty = (state_q == ST_FULL);
  assign bus.free_count = free_count_q;
  assign bus.rel_err    = rel_err_q;
endmodule

// File: doc/atid_pool_allocator.md
Name: atid_pool_allocator

Overview:
- Parametrised ATB trace-ID allocator: hands out unique ATIDs to NUM_CH trace sources and accepts released IDs back.
- Successor to the single-counter ATID generator. Adds an in-use bitmap, a multi-channel round-robin grant handshake, ID release with error detection, and a configurable reserved range.
- Sits between the trace-source enable logic and the ATB funnel programming interface.

Parameters:
- ID_W, 8: ATID width; ID space 0..2^ID_W-1.
- NUM_CH, 4: number of requesting channels (≥1).
- RSV_LO, 8'h70: first reserved ID, never allocated.
- RSV_HI, 8'h7F: last reserved ID (RSV_LO ≤ RSV_HI < 2^ID_W-1; RSV_LO ≥ 2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CH  per-channel allocation request, held until granted
- req_ready  out  NUM_CH  one-hot grant; at most one bit high per cycle
- alloc_id  out  ID_W  allocated ID; valid when any req_ready bit is high
- rel_valid  in  1  release strobe
- rel_id  in  ID_W  ID being released
- rel_err  out  1  registered pulse: previous-cycle release was illegal
- pool_empty  out  1  no allocatable ID exists (state FULL)
- free_count  out  ID_W+1  number of free allocatable IDs

Behaviour:
- Allocatable IDs: every ID except 0 and RSV_LO..RSV_HI. NVALID = 2^ID_W-1-(RSV_HI-RSV_LO+1); default 239.
- next(x): if x==RSV_LO-1 then RSV_HI+1; else if x==2^ID_W-1 then 1; else x+1.
- State: used[2^ID_W] bitmap, ptr, cand_id, last_gnt, free_count, FSM {SCAN, READY, FULL}.
- Reset values: all used=0, ptr=1, state=SCAN, cand_id=0, last_gnt=NUM_CH-1, free_count=NVALID, req_ready=0, alloc_id=0, rel_err=0, pool_empty=0.
- SCAN:
  - If free_count==0 and no legal release this cycle: go to FULL.
  - Else if used[ptr]==0 (registered value): cand_id<=ptr, go to READY.
  - Else ptr<=next(ptr).
  - Advances one ID per cycle.
- READY:
  - req_ready = round-robin pick among req_valid, searching from last_gnt+1 upward and wrapping.
  - alloc_id = cand_id while READY; 0 otherwise.
  - On a grant: used[cand_id]<=1, last_gnt<=granted channel, ptr<=next(cand_id), go to SCAN.
  - No request: hold READY.
- FULL:
  - pool_empty=1, req_ready=0.
  - On a legal release: ptr<=rel_id, go to SCAN.
- Grant latency: after reset, first grant is possible in cycle 2 (cycle 1 SCAN, cycle 2 READY). After a grant, the next grant is no earlier than 2 cycles later. Max throughput is one grant per 2 cycles.
- Release:
  - Legal iff rel_id is allocatable and used[rel_id]==1.
  - Legal: used[rel_id]<=0, free_count+1.
  - Illegal (0, reserved, out-of-range, or not in use): no state change; rel_err=1 the next cycle for one cycle.
- Simultaneous grant and legal release: both apply; free_count unchanged.
- Grant only: free_count-1.
- Release of the ID at ptr during SCAN in the same cycle: the scan uses the old bit, skips it, and finds it on wraparound.
- cand_id is never in use, so it cannot be legally released while READY.
- req_valid dropped while READY: no grant; cand_id is retained.
- Reset asserted mid-operation: all state returns to reset values immediately; outstanding allocations are forgotten.

Test Plan:
- Reset, hold req_valid[0]=1 → first grant in cycle 2 with alloc_id=0x01. Subsequent grants 0x02, 0x03, … every 2 cycles. rel_err=0.
- Allocate through 0x6F → next alloc_id=0x80, never 0x70..0x7F. After 0xFF, release 0x05 → scan wraps past 0, and 0x05 is the next alloc_id.
- req_valid=4'b1111 continuously → grants cycle ch0, ch1, ch2, ch3, ch0 with IDs 0x01..0x05. req_ready is one-hot in every cycle.
- Allocate all 239 IDs → pool_empty=1, free_count=0, no further grants. Release 0x42 → pool_empty drops, next alloc_id=0x42.
- Release 0x00, then 0x75, then never-allocated 0x30 → rel_err pulses 1 cycle after each. free_count and bitmap unchanged.
- Grant coincident with legal release of 0x03 → free_count unchanged. Assert reset mid-SCAN → free_count=239, ptr=1, next alloc_id=0x01.
